maze_solve: RTL and testbench

Wall-following maze solver that sits directly upstream of the navigation state machine. It issues heading and forward-move commands (strt_hdng/dsrd_hdng, strt_mv, stp_lft/stp_rght) and consumes that machine's mv_cmplt handshake. It uses the IR opening flags to choose the next direction under a left- or right-hand affinity, and stops issuing commands once the magnet/solution flag is seen.

---
 rtl/maze_pkg.sv | 43 ++++
 rtl/maze_solve_settle_timer.sv | 35 +++
 rtl/maze_solve.sv | 162 ++++++++++++++++
 tb/tb_maze_solve.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze solver and its neighbours.
//   dir_t        : direction index (NORTH=0, WEST=1, SOUTH=2, EAST=3); left turn is +1 mod 4
//   HDNG_*       : 12-bit heading codes understood by the navigation block
//   state_t      : solver FSM states
//   dir_to_hdng  : direction index to heading code
package maze_pkg;

    typedef enum logic [1:0] {
        NORTH = 2'd0,
        WEST  = 2'd1,
        SOUTH = 2'd2,
        EAST  = 2'd3
    } dir_t;

    localparam logic [11:0] HDNG_N = 12'h000;
    localparam logic [11:0] HDNG_W = 12'h3FF;
    localparam logic [11:0] HDNG_S = 12'h7FF;
    localparam logic [11:0] HDNG_E = 12'hC00;

    typedef enum logic [2:0] {
        IDLE,
        MV_ISSUE,
        MV_WAIT,
        SETTLE,
        DECIDE,
        HDNG_WAIT,
        DONE
    } state_t;

    function automatic logic [11:0] dir_to_hdng(input dir_t d);
        logic [11:0] h;
        h = HDNG_N;
        case (d)
            NORTH:   h = HDNG_N;
            WEST:    h = HDNG_W;
            SOUTH:   h = HDNG_S;
            EAST:    h = HDNG_E;
            default: h = HDNG_N;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/maze_solve_settle_timer.sv
// Settle timer: counts the cycles spent waiting for the IR flags to settle.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (has priority over en)
//   en         : advance the count by one
//   done       : high in the last of SETTLE_CYC counted cycles
module maze_solve_settle_timer #(
    parameter int unsigned SETTLE_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    // A zero settle time never enters the counting state; keep one bit so the
    // counter stays well-formed in that configuration.
    localparam int unsigned CW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam logic [CW-1:0] LAST = (SETTLE_CYC > 0) ? CW'(SETTLE_CYC - 1) : '0;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign done = (cnt_q == LAST);

endmodule

// File: rtl/maze_solve.sv
// Wall-following maze solver driving the navigation state machine.
//   clk, rst_n            : clock, asynchronous active-low reset
//   cmd_md                : solve enable (level), low aborts to IDLE
//   cmd0                  : affinity, 1 = left-hand, 0 = right-hand (latched leaving IDLE)
//   lft_opn/rght_opn/frwrd_opn : IR opening flags, sampled in DECIDE
//   mv_cmplt              : navigation done pulse (heading or move)
//   sol_cmplt             : magnet seen, maze solved
//   strt_hdng, dsrd_hdng  : heading-change pulse and target heading
//   strt_mv               : forward-move pulse
//   stp_lft, stp_rght     : stop-at-opening qualifiers while active
//   solved                : high while in DONE
// All outputs are registered.
module maze_solve #(
    parameter int unsigned SETTLE_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_md,
    input  logic        cmd0,
    input  logic        lft_opn,
    input  logic        rght_opn,
    input  logic        frwrd_opn,
    input  logic        mv_cmplt,
    input  logic        sol_cmplt,
    output logic        strt_hdng,
    output logic [11:0] dsrd_hdng,
    output logic        strt_mv,
    output logic        stp_lft,
    output logic        stp_rght,
    output logic        solved
);

    import maze_pkg::*;

    state_t      state_q, state_d;
    dir_t        dir_q, dir_d;
    logic        aff_q, aff_d;
    logic [11:0] hdng_q, hdng_d;
    logic        strt_hdng_q, strt_hdng_d;
    logic        strt_mv_q, strt_mv_d;
    logic        stp_lft_q, stp_rght_q, solved_q;
    logic        active_d;
    logic        settle_clr, settle_done;
    logic        first_opn, second_opn;
    logic [1:0]  first_step, second_step;

    // Affinity-ordered view of the side openings: the preferred side is tried
    // first, then forward, then the other side.
    assign first_opn   = aff_q ? lft_opn : rght_opn;
    assign second_opn  = aff_q ? rght_opn : lft_opn;
    assign first_step  = aff_q ? 2'd1 : 2'd3;
    assign second_step = aff_q ? 2'd3 : 2'd1;

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        aff_d       = aff_q;
        hdng_d      = hdng_q;
        strt_hdng_d = 1'b0;
        strt_mv_d   = 1'b0;

        if (!cmd_md) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            state_d = MV_ISSUE;
            aff_d   = cmd0;
        end else if (state_q == DONE) begin
            state_d = DONE;
        end else if (sol_cmplt) begin
            state_d = DONE;
        end else begin
            case (state_q)
                MV_ISSUE: begin
                    strt_mv_d = 1'b1;
                    state_d   = MV_WAIT;
                end
                MV_WAIT: begin
                    if (mv_cmplt) begin
                        state_d = (SETTLE_CYC == 0) ? DECIDE : SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_done) begin
                        state_d = DECIDE;
                    end
                end
                DECIDE: begin
                    // Going straight issues the move from here so that every
                    // decision produces its pulse on the following cycle.
                    if (!first_opn && frwrd_opn) begin
                        strt_mv_d = 1'b1;
                        state_d   = MV_WAIT;
                    end else begin
                        if (first_opn) begin
                            dir_d = dir_t'(dir_q + first_step);
                        end else if (second_opn) begin
                            dir_d = dir_t'(dir_q + second_step);
                        end else begin
                            dir_d = dir_t'(dir_q + 2'd2);
                        end
                        hdng_d      = dir_to_hdng(dir_d);
                        strt_hdng_d = 1'b1;
                        state_d     = HDNG_WAIT;
                    end
                end
                HDNG_WAIT: begin
                    if (mv_cmplt) begin
                        state_d = MV_ISSUE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    assign active_d = (state_d != IDLE) && (state_d != DONE);

    // Counter runs only while staying in SETTLE; any other cycle clears it.
    assign settle_clr = (state_q != SETTLE) || (state_d != SETTLE);

    maze_solve_settle_timer #(
        .SETTLE_CYC(SETTLE_CYC)
    ) u_settle_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (settle_clr),
        .en   (!settle_clr),
        .done (settle_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dir_q       <= NORTH;
            aff_q       <= 1'b0;
            hdng_q      <= HDNG_N;
            strt_hdng_q <= 1'b0;
            strt_mv_q   <= 1'b0;
            stp_lft_q   <= 1'b0;
            stp_rght_q  <= 1'b0;
            solved_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            aff_q       <= aff_d;
            hdng_q      <= hdng_d;
            strt_hdng_q <= strt_hdng_d;
            strt_mv_q   <= strt_mv_d;
            stp_lft_q   <= aff_d & active_d;
            stp_rght_q  <= ~aff_d & active_d;
            solved_q    <= (state_d == DONE);
        end
    end

    assign strt_hdng = strt_hdng_q;
    assign dsrd_hdng = hdng_q;
    assign strt_mv   = strt_mv_q;
    assign stp_lft   = stp_lft_q;
    assign stp_rght  = stp_rght_q;
    assign solved    = solved_q;

endmodule

// File: tb/tb_maze_solve.sv
// Self-checking bench for maze_solve: a table of decisions plus hand-written
// sequences for solve, abort and reset. Expected pulses (kind, heading, cycle)
// are queued when stimulus is driven and popped when the DUT pulses.
module tb_maze_solve;

    localparam int unsigned S = 16;

    logic        clk, rst_n, cmd_md, cmd0;
    logic        lft_opn, rght_opn, frwrd_opn, mv_cmplt, sol_cmplt;
    logic        strt_hdng, strt_mv, stp_lft, stp_rght, solved;
    logic [11:0] dsrd_hdng;

    maze_solve #(
        .SETTLE_CYC(S)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_md   (cmd_md),
        .cmd0     (cmd0),
        .lft_opn  (lft_opn),
        .rght_opn (rght_opn),
        .frwrd_opn(frwrd_opn),
        .mv_cmplt (mv_cmplt),
        .sol_cmplt(sol_cmplt),
        .strt_hdng(strt_hdng),
        .dsrd_hdng(dsrd_hdng),
        .strt_mv  (strt_mv),
        .stp_lft  (stp_lft),
        .stp_rght (stp_rght),
        .solved   (solved)
    );

    typedef struct {
        logic        kind;  // 1 = strt_hdng, 0 = strt_mv
        logic [11:0] hdng;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        aff;
        logic        l;
        logic        f;
        logic        r;
        logic        turn;
        logic [11:0] hdng;
    } vec_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    vec_t        vecs[13];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cur_aff;
    logic [11:0] held;
    logic        prev_mv = 1'b0;
    logic        prev_hdng = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic kind, input logic [11:0] hdng, input int at);
        exp_t e;
        e.kind = kind;
        e.hdng = hdng;
        e.cyc  = at;
        sb_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb_q.size() > 0) begin
            check("pulse_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic start(input logic aff);
        cmd0   = aff;
        cmd_md = 1'b1;
        push(1'b0, held, cyc + 2);
        tick();
        drain(8);
        check("stp_lft", 32'(stp_lft), 32'(aff));
        check("stp_rght", 32'(stp_rght), 32'(!aff));
    endtask

    task automatic abort_to_idle();
        cmd_md = 1'b0;
        tick();
        tick();
        check("abort_stp_lft", 32'(stp_lft), 32'd0);
        check("abort_stp_rght", 32'(stp_rght), 32'd0);
    endtask

    // Move completes in MV_WAIT with the given flags; one decision follows.
    task automatic apply(input vec_t v);
        int c;
        c         = cyc;
        lft_opn   = v.l;
        frwrd_opn = v.f;
        rght_opn  = v.r;
        mv_cmplt  = 1'b1;
        if (v.turn) begin
            held = v.hdng;
            push(1'b1, v.hdng, c + 2 + S);
        end else begin
            push(1'b0, held, c + 2 + S);
        end
        tick();
        mv_cmplt = 1'b0;
        drain(S + 8);
        if (v.turn) begin
            c        = cyc;
            mv_cmplt = 1'b1;
            push(1'b0, held, c + 2);
            tick();
            mv_cmplt = 1'b0;
            drain(8);
        end
        lft_opn   = 1'b0;
        frwrd_opn = 1'b0;
        rght_opn  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && (strt_mv || strt_hdng)) begin
            check("pulse_overlap", 32'(strt_mv & strt_hdng), 32'd0);
            if (strt_mv) check("strt_mv_width", 32'(prev_mv), 32'd0);
            if (strt_hdng) check("strt_hdng_width", 32'(prev_hdng), 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", 32'({strt_hdng, strt_mv}), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_kind", 32'(strt_hdng), 32'(mon_e.kind));
                check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("dsrd_hdng", 32'(dsrd_hdng), 32'(mon_e.hdng));
            end
        end
        prev_mv   <= strt_mv;
        prev_hdng <= strt_hdng;
    end

    initial begin
        // {aff, lft, frwrd, rght, turn, expected heading}; runs in order from NORTH.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h3FF}; // left -> W
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h7FF}; // left -> S
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'hC00}; // left -> E
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000}; // left -> N (wrap)
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000}; // forward beats right
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'hC00}; // right -> E
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h3FF}; // U-turn -> W
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000}; // right aff: right -> N
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000}; // forward beats left
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h3FF}; // left -> W
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000}; // right -> N
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'hC00}; // right -> E
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h3FF}; // dead end at E -> W

        rst_n = 1'b0; cmd_md = 1'b0; cmd0 = 1'b0;
        lft_opn = 1'b0; rght_opn = 1'b0; frwrd_opn = 1'b0;
        mv_cmplt = 1'b0; sol_cmplt = 1'b0;
        held = 12'h000;
        cur_aff = -1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_strt_hdng", 32'(strt_hdng), 32'd0);
        check("rst_strt_mv", 32'(strt_mv), 32'd0);
        check("rst_stp_lft", 32'(stp_lft), 32'd0);
        check("rst_stp_rght", 32'(stp_rght), 32'd0);
        check("rst_solved", 32'(solved), 32'd0);
        check("rst_dsrd_hdng", 32'(dsrd_hdng), 32'h000);
        tick();

        for (int i = 0; i < 13; i++) begin
            if (int'(vecs[i].aff) != cur_aff) begin
                if (cur_aff >= 0) abort_to_idle();
                start(vecs[i].aff);
                cur_aff = int'(vecs[i].aff);
            end
            apply(vecs[i]);
        end

        // Solved together with move complete: DONE wins, no more pulses.
        mv_cmplt  = 1'b1;
        sol_cmplt = 1'b1;
        tick();
        mv_cmplt  = 1'b0;
        sol_cmplt = 1'b0;
        check("solved_set", 32'(solved), 32'd1);
        check("done_stp_rght", 32'(stp_rght), 32'd0);
        repeat (S + 6) tick();
        check("solved_hold", 32'(solved), 32'd1);
        cmd_md = 1'b0;
        tick();
        check("solved_clear", 32'(solved), 32'd0);

        // Abort while settling: straight to IDLE, no pulse, heading kept.
        start(1'b1);
        lft_opn  = 1'b1;
        mv_cmplt = 1'b1;
        tick();
        mv_cmplt = 1'b0;
        repeat (5) tick();
        cmd_md = 1'b0;
        tick();
        check("settle_abort_stp_lft", 32'(stp_lft), 32'd0);
        repeat (S + 6) tick();
        lft_opn = 1'b0;
        check("abort_keeps_hdng", 32'(dsrd_hdng), 32'(held));

        // Reset while waiting for a heading change.
        start(1'b1);
        apply_turn_only();
        #2 rst_n = 1'b0;
        #1;
        check("arst_strt_hdng", 32'(strt_hdng), 32'd0);
        check("arst_strt_mv", 32'(strt_mv), 32'd0);
        check("arst_stp_lft", 32'(stp_lft), 32'd0);
        check("arst_stp_rght", 32'(stp_rght), 32'd0);
        check("arst_solved", 32'(solved), 32'd0);
        check("arst_dsrd_hdng", 32'(dsrd_hdng), 32'h000);
        cmd_md = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("post_rst_idle", 32'(stp_lft), 32'd0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // From MV_WAIT facing WEST: left opening turns to SOUTH, leaving HDNG_WAIT.
    task automatic apply_turn_only();
        int c;
        c        = cyc;
        lft_opn  = 1'b1;
        mv_cmplt = 1'b1;
        push(1'b1, 12'h7FF, c + 2 + S);
        tick();
        mv_cmplt = 1'b0;
        drain(S + 8);
        lft_opn = 1'b0;
    endtask

endmodule
